// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: serial-audio transmit master (I2S, left-justified, TDM).
// Generates sclk/lrclk from MCLK, fetches one frame of samples per frame
// from an upstream FIFO and serialises it MSB first.
// Optional feature macro: I2S_TDM_TX_UNDERRUN_EN adds underrun/underrun_count.
module i2s_tdm_tx #(
    parameter int unsigned DW       = 24,
    parameter int unsigned SLOT_W   = 32,
    parameter int unsigned NCH      = 2,
    parameter int unsigned FS_RATIO = 256,
    parameter int unsigned MODE     = 0,
    parameter int unsigned EARLY    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH*DW-1:0]   samples,
    output logic                rd_en,
    input  logic                rd_valid,
    output logic                rd_early,
    output logic                sclk,
    output logic                lrclk,
`ifdef I2S_TDM_TX_UNDERRUN_EN
    output logic                underrun,
    output logic [15:0]         underrun_count,
`endif
    output logic                sdo
);

    localparam int unsigned FRAME = NCH * SLOT_W;
    localparam int unsigned DIV   = (FRAME > 0) ? FS_RATIO / FRAME : 0;
    localparam int unsigned CW    = (FS_RATIO > 2) ? $clog2(FS_RATIO) : 1;

    localparam logic [CW-1:0]     C_LAST = CW'(FS_RATIO - 1);
    localparam logic [CW-1:0]     C_CAP  = CW'(FS_RATIO - 2);
    localparam logic [NCH*DW-1:0] C_LSB  = {{(NCH*DW-1){1'b0}}, 1'b1};

    if (FRAME == 0 || (FS_RATIO % FRAME) != 0 || DIV < 2 || (DIV % 2) != 0 ||
        DW > SLOT_W || DW == 0 || EARLY + 4 > FS_RATIO || MODE > 2 ||
        (MODE < 2 && NCH != 2) || (MODE == 2 && NCH < 2)) begin : g_bad_cfg
        $error("i2s_tdm_tx: illegal parameter combination");
    end

    logic [CW-1:0]     r_cnt;
    logic [NCH*DW-1:0] r_hold;
    logic [NCH*DW-1:0] r_active;
    logic              r_sclk;
    logic              r_lrclk;
    logic              r_sdo;
    logic              r_rd_en;
    logic              r_rd_early;

    int unsigned       w_cur;
    int unsigned       w_nxt;
    int unsigned       w_b;
    int unsigned       w_ph;
    int unsigned       w_s;
    int unsigned       w_p;
    logic [NCH*DW-1:0] w_src;
    logic              w_sclk;
    logic              w_lrclk;
    logic              w_sdo;
    logic              w_rd_en;
    logic              w_rd_early;

    // Output equations evaluated for the next count so every output is a flop.
    always_comb begin
        w_cur = 32'(r_cnt);
        w_nxt = (w_cur == FS_RATIO - 1) ? 32'd0 : w_cur + 32'd1;
        w_b   = w_nxt / DIV;
        w_ph  = w_nxt % DIV;
        w_s   = w_b / SLOT_W;
        w_p   = w_b % SLOT_W;
        // At the frame boundary active is being reloaded, so look at hold directly.
        w_src = (r_cnt == C_LAST) ? r_hold : r_active;
        w_sdo = 1'b0;
        if (w_p < DW) begin
            w_sdo = ((w_src >> (w_s * DW + (DW - 1 - w_p))) & C_LSB) != '0;
        end
        if (MODE == 0) begin
            w_lrclk = ((w_b + 32'd1) % FRAME) >= SLOT_W;
        end else if (MODE == 1) begin
            w_lrclk = w_b < SLOT_W;
        end else begin
            w_lrclk = w_b == FRAME - 1;
        end
        w_sclk     = w_ph >= DIV / 2;
        w_rd_early = w_nxt == FS_RATIO - 3 - EARLY;
        w_rd_en    = w_nxt == FS_RATIO - 3;
    end

    // Frame counter, sample capture and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_hold     <= '0;
            r_active   <= '0;
            r_sclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_sdo      <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_early <= 1'b0;
        end else begin
            r_cnt      <= CW'(w_nxt);
            r_sclk     <= w_sclk;
            r_lrclk    <= w_lrclk;
            r_sdo      <= w_sdo;
            r_rd_en    <= w_rd_en;
            r_rd_early <= w_rd_early;
            if (r_cnt == C_CAP) begin
                // Missing data mutes the whole next frame.
                r_hold <= rd_valid ? samples : '0;
            end
            if (r_cnt == C_LAST) begin
                r_active <= r_hold;
            end
        end
    end

`ifdef I2S_TDM_TX_UNDERRUN_EN
    logic        r_underrun;
    logic [15:0] r_underrun_count;

    // Underrun flag and saturating counter, updated at the capture point.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_underrun       <= 1'b0;
            r_underrun_count <= 16'd0;
        end else begin
            r_underrun <= (r_cnt == C_CAP) && !rd_valid;
            if ((r_cnt == C_CAP) && !rd_valid && (r_underrun_count != 16'hFFFF)) begin
                r_underrun_count <= r_underrun_count + 16'd1;
            end
        end
    end

    assign underrun       = r_underrun;
    assign underrun_count = r_underrun_count;
`endif

    assign sclk     = r_sclk;
    assign lrclk    = r_lrclk;
    assign sdo      = r_sdo;
    assign rd_en    = r_rd_en;
    assign rd_early = r_rd_early;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Bench for i2s_tdm_tx: three instances (I2S, LJ with EARLY=0, 8-channel TDM)
// driven with directed then random frames and compared every cycle against a
// frame-level reference model.
module tb_i2s_tdm_tx;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_valid;
    logic         directed;
    logic [191:0] rnd;
    bit           checking = 1'b0;
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned MD = g;
        localparam int unsigned NC = (g == 2) ? 8 : 2;
        localparam int unsigned FS = (g == 2) ? 512 : 256;
        localparam int unsigned SW = 32;
        localparam int unsigned D  = 24;
        localparam int unsigned FR = NC * SW;
        localparam int unsigned DV = FS / FR;
        localparam int unsigned E  = (g == 1) ? 0 : 4;

        logic [NC*D-1:0] smp;
        logic [NC*D-1:0] pat;
        logic            o_rd_en;
        logic            o_rd_early;
        logic            o_sclk;
        logic            o_lrclk;
        logic            o_sdo;
`ifdef I2S_TDM_TX_UNDERRUN_EN
        logic            o_underrun;
        logic [15:0]     o_underrun_count;
`endif

        always_comb begin
            pat = '0;
            for (int k = 0; k < NC; k++) begin
                if (g == 2) pat[k*D +: D] = D'(k * 32'h111111);
                else        pat[k*D +: D] = (k == 0) ? 24'hA5A5A5 : 24'h5A5A5A;
            end
            smp = directed ? pat : rnd[NC*D-1:0];
        end

        i2s_tdm_tx #(
            .DW(D), .SLOT_W(SW), .NCH(NC), .FS_RATIO(FS), .MODE(MD), .EARLY(E)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .samples       (smp),
            .rd_en         (o_rd_en),
            .rd_valid      (rd_valid),
            .rd_early      (o_rd_early),
            .sclk          (o_sclk),
            .lrclk         (o_lrclk),
`ifdef I2S_TDM_TX_UNDERRUN_EN
            .underrun      (o_underrun),
            .underrun_count(o_underrun_count),
`endif
            .sdo           (o_sdo)
        );

        function automatic logic bit_of(input logic [NC*D-1:0] v, input int unsigned i);
            logic [NC*D-1:0] t;
            t = v >> i;
            return t[0];
        endfunction

        // Reference: expected count, captured frame and serial image of the frame.
        int              m_cnt;
        logic [NC*D-1:0] m_hold;
        logic            m_rst;
        logic            m_und;
        int              m_ucnt;
        logic            exp_bits [FR];

        always @(posedge clk) begin
            if (!rst) begin
                m_cnt  <= 0;
                m_hold <= '0;
                m_rst  <= 1'b1;
                m_und  <= 1'b0;
                m_ucnt <= 0;
                for (int b = 0; b < FR; b++) exp_bits[b] <= 1'b0;
            end else begin
                m_rst <= 1'b0;
                m_und <= (m_cnt == FS - 2) && !rd_valid;
                if (m_cnt == FS - 2) begin
                    m_hold <= rd_valid ? smp : '0;
                    if (!rd_valid && m_ucnt < 65535) m_ucnt <= m_ucnt + 1;
                end
                if (m_cnt == FS - 1) begin
                    for (int b = 0; b < FR; b++) begin
                        exp_bits[b] <= ((b % SW) < D) ?
                            bit_of(m_hold, (b / SW) * D + D - 1 - (b % SW)) : 1'b0;
                    end
                end
                m_cnt <= (m_cnt + 1) % FS;
            end
        end

        always @(negedge clk) begin
            if (checking) begin
                int b;
                logic e_sclk, e_lr, e_sdo, e_rd, e_early, e_und;
                b       = m_cnt / DV;
                e_sclk  = (m_cnt % DV) >= DV / 2;
                e_sdo   = exp_bits[b];
                e_rd    = m_cnt == FS - 3;
                e_early = m_cnt == FS - 3 - E;
                e_und   = m_und;
                if (MD == 0)      e_lr = ((b + 1) % FR) >= SW;
                else if (MD == 1) e_lr = b < SW;
                else              e_lr = b == FR - 1;
                if (m_rst) begin
                    e_sclk = 0; e_lr = 0; e_sdo = 0; e_rd = 0; e_early = 0; e_und = 0;
                end
                check($sformatf("i%0d_sclk_c%0d", g, m_cnt), 32'(o_sclk), 32'(e_sclk));
                check($sformatf("i%0d_lrclk_c%0d", g, m_cnt), 32'(o_lrclk), 32'(e_lr));
                check($sformatf("i%0d_sdo_c%0d", g, m_cnt), 32'(o_sdo), 32'(e_sdo));
                check($sformatf("i%0d_rd_en_c%0d", g, m_cnt), 32'(o_rd_en), 32'(e_rd));
                check($sformatf("i%0d_rd_early_c%0d", g, m_cnt), 32'(o_rd_early),
                      32'(e_early));
`ifdef I2S_TDM_TX_UNDERRUN_EN
                check($sformatf("i%0d_underrun_c%0d", g, m_cnt), 32'(o_underrun),
                      32'(e_und));
                check($sformatf("i%0d_ucount_c%0d", g, m_cnt), 32'(o_underrun_count),
                      32'(m_ucnt));
`else
                if (e_und === 1'bx) $display("model underrun flag undefined");
`endif
            end
        end
    end

    // Reset, directed frame, underrun frames, random traffic, mid-frame reset.
    initial begin
        rst      = 1'b0;
        rd_valid = 1'b1;
        directed = 1'b1;
        rnd      = '0;
        @(posedge clk);
        #1 checking = 1'b1;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            // Inputs for the cycle with cnt == c mod FS.
            directed = (c < 512);
            if (c < 512)       rd_valid = 1'b1;
            else if (c < 1024) rd_valid = 1'b0;
            else               rd_valid = ($urandom_range(0, 3) != 0);
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rst = (c != 1636);
            @(posedge clk);
            #1;
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_tdm_tx.md
# i2s_tdm_tx

Parametrised serial-audio transmit master combining bit-clock/frame-clock generation and serialisation in one block. Generalises the two-channel I2S master to I2S, left-justified and multi-channel TDM framing, with data width independent of slot width. Sits between a sample FIFO (read-enable/valid handshake with an early warning) and the DAC/codec pins. Runs on the master clock (MCLK).

## Interface
- `DW`, 24: data bits per channel; MSB first, zero-padded to `SLOT_W`.
- `SLOT_W`, 32: sclk periods per channel slot; `DW <= SLOT_W`.
- `NCH`, 2: channels per frame; must be 2 for `MODE` 0/1, and 2 or more for `MODE` 2.
- `FS_RATIO`, 256: clk cycles per frame (MCLK/LRCLK).
- `MODE`, 0: 0 = I2S, 1 = left-justified, 2 = TDM (DSP-A style one-bit frame sync).
- `EARLY`, 4: clk cycles by which `rd_early` precedes `rd_en`; range 0..FS_RATIO-4.
- Derived values:
  - `FRAME = NCH*SLOT_W`.
  - `DIV = FS_RATIO/FRAME`, which must be an even integer ≥2; violation is an elaboration `$error`.

Ports:
- `clk`  in  1  MCLK; the block has one clock.
- `rst`  in  1  reset, synchronous, active-low (`rst=0` resets).
- `samples`  in  NCH*DW  channel k at `[k*DW +: DW]`; channel 0 is left for I2S/LJ.
- `rd_en`  out  1  one-cycle read request to the upstream FIFO.
- `rd_valid`  in  1  upstream data valid, sampled one cycle after `rd_en`.
- `rd_early`  out  1  one-cycle prefetch warning.
- `sclk`  out  1  bit clock, `clk/DIV`.
- `lrclk`  out  1  word select (I2S/LJ) or frame sync (TDM).
- `sdo`  out  1  serial data.
- `underrun`  out  1  present only with the configuration macro (see Configuration).
- `underrun_count`  out  16  present only with the configuration macro (see Configuration).

## Operation
- Frame counter `cnt`:
  - Free-running, 0..FS_RATIO-1, wraps to 0.
  - Bit index `b = cnt/DIV`, range 0..FRAME-1.
  - `ph = cnt%DIV`.
- `sclk`: 0 for `ph < DIV/2`, 1 otherwise.
- `sdo` for bit b:
  - Slot `s = b/SLOT_W`, position `p = b%SLOT_W`.
  - Bit equals `active[s][DW-1-p]` when `p < DW`, else 0.
- `lrclk` by mode:
  - I2S: `((b+1)%FRAME) >= SLOT_W`. lrclk leads the MSB by one bit; left channel is low.
  - LJ: `b < SLOT_W`. Left channel is high, aligned with the MSB.
  - TDM: `b == FRAME-1`. One sclk high, immediately before slot 0 MSB.
- Fetch handshake:
  - `rd_early` is high only at `cnt == FS_RATIO-3-EARLY`.
  - `rd_en` is high only at `cnt == FS_RATIO-3`.
- Capture at `cnt == FS_RATIO-2`:
  - If `rd_valid=1`, the holding register takes `samples`.
  - Otherwise the holding register is loaded with zeros (mute frame).
- `active` loads from the holding register at `cnt == FS_RATIO-1`; it is used for the whole next frame.

## Timing
- All outputs are flops; no combinational path from inputs to outputs.
- Outputs in the cycle where `cnt=c` reflect the equations for c, computed from the next-count value.
- `sdo` and `lrclk` change only at `ph==0`, i.e. on the sclk falling edge. The receiver samples on the rising edge.
- Latency: samples captured in frame N appear on `sdo` starting at `cnt=0` of frame N+1.
- Reset (`rst=0` at a rising edge):
  - `cnt`, holding and `active` are cleared.
  - `sclk`, `lrclk`, `sdo`, `rd_en`, `rd_early`, `underrun` are 0; `underrun_count` is 0.
- First cycle after release (`cnt=0`):
  - Outputs still hold their reset values; equations apply from `cnt=1`.
  - In LJ mode `lrclk` therefore rises at `cnt=1`.
  - The first frame is all zeros; the first `rd_en` occurs at `cnt=FS_RATIO-3`.
- Reset mid-frame: takes effect on the next edge. The frame is abandoned and no partial `rd_en` is issued.
- `rd_valid` is ignored in all cycles other than `cnt==FS_RATIO-2`.
- `EARLY=0`: `rd_early` and `rd_en` coincide.

## Configuration
- `I2S_TDM_TX_UNDERRUN_EN` defined:
  - `underrun` pulses one cycle at `cnt==FS_RATIO-2` when `rd_valid=0`.
  - `underrun_count` increments at the same point and saturates at 0xFFFF. It clears only on reset.
- Undefined:
  - Both ports and their logic are absent.
  - Mute-on-underrun behaviour is identical.

## Test plan
- Reset with defaults:
  - Stimulus: hold `rst=0` for 10 cycles, then release.
  - Response: all outputs 0 during reset. `rd_early` at cycle 249 and `rd_en` at cycle 253 after release. `sclk` has period 4 clk.
- I2S, defaults:
  - Stimulus: L=0xA5A5A5, R=0x5A5A5A, `rd_valid=1`.
  - Response, next frame: bits 0..23 carry 0xA5A5A5 MSB first; bits 24..31 are 0. `lrclk` rises at b=31 and falls at b=63. R appears at b=32..55.
- LJ (`MODE=1`), same data:
  - `lrclk` is 1 for b=0..31.
  - L MSB at b=0, R MSB at b=32.
- TDM (`MODE=2`, `NCH=8`, `FS_RATIO=512`, DIV=2):
  - Stimulus: channel k = `k*0x111111`.
  - Response: slot k carries that value. `lrclk` is high only during b=255.
- Underrun, macro defined:
  - Stimulus: `rd_valid=0` for one frame, then valid data.
  - Response: next frame `sdo` is all 0, `underrun` pulses once, `underrun_count=1`. The following frame is normal.
- Reset mid-frame:
  - Stimulus: assert `rst=0` at `cnt=100` for 1 cycle.
  - Response: outputs are 0 next cycle. `cnt` restarts at 0. The next frame is zeros.
